// File: rtl/gestor_pkg.sv
// Shared types and constants for the parking barrier controller.
package gestor_pkg;

  typedef enum logic [1:0] {
    REPOUSO = 2'd0,
    ABERTA  = 2'd1,
    FECHO   = 2'd2
  } estado_t;

  localparam logic SENTIDO_ENTRADA = 1'b0;
  localparam logic SENTIDO_SAIDA   = 1'b1;

  // Six 4-bit plate digits, m5 in [23:20] down to m0 in [3:0].
  typedef logic [23:0] matricula_t;

endpackage

// File: rtl/registo_matriculas.sv
// Four-entry FIFO log of accepted plates.
// When the log is full, a write without a read drops the oldest entry.
// A read of an empty log is ignored.
module registo_matriculas
  import gestor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       escrever,
  input  matricula_t dado,
  input  logic       ler,
  output matricula_t hist_dado,
  output logic       hist_vazio
);

  localparam int PROF = 4;

  matricula_t mem [PROF];
  logic [1:0] ptr_esc;
  logic [1:0] ptr_ler;
  logic [2:0] ocup;
  logic       pop;
  logic       descarta;
  logic       inc;

  // Decide pop, overwrite-oldest and occupancy increment for this cycle.
  always_comb begin
    pop      = ler && (ocup != 3'd0);
    descarta = escrever && (ocup == 3'd4) && !pop;
    inc      = escrever && !descarta;
  end

  // Pointers and occupancy; reset empties the log.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_esc <= 2'd0;
      ptr_ler <= 2'd0;
      ocup    <= 3'd0;
    end else begin
      if (escrever) ptr_esc <= ptr_esc + 2'd1;
      if (pop || descarta) ptr_ler <= ptr_ler + 2'd1;
      ocup <= ocup + {2'b00, inc} - {2'b00, pop};
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (escrever) mem[ptr_esc] <= dado;
  end

  assign hist_dado  = mem[ptr_ler];
  assign hist_vazio = (ocup == 3'd0);

endmodule

// File: rtl/gestor_barreira.sv
// Parking barrier controller: accepts validated plate requests, opens the
// barrier, counts vehicles in/out, and applies a guard period after closing.
// Optional macro GESTOR_REGISTO_EN adds a 4-entry log of accepted plates
// (ports ler, hist_dado, hist_vazio).
//
// state   | meaning
// REPOUSO | idle, accepting requests
// ABERTA  | barrier open, waiting for passage or timeout
// FECHO   | barrier closed, guard time before returning to idle
module gestor_barreira
  import gestor_pkg::*;
#(
  parameter int LOTACAO  = 9,
  parameter int T_ABERTA = 5,
  parameter int T_FECHO  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pedido,
  input  logic       valido,
  input  logic       sentido,
  input  matricula_t matricula,
  input  logic       passou,
  output logic       barreira,
  output logic       ocupado,
  output logic       recusado,
  output logic [3:0] contagem,
  output logic       cheio,
  output matricula_t ult_matricula
`ifdef GESTOR_REGISTO_EN
  ,
  input  logic       ler,
  output matricula_t hist_dado,
  output logic       hist_vazio
`endif
);

  localparam int TMAX = (T_ABERTA > T_FECHO) ? T_ABERTA : T_FECHO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // Down-counters load N-1 so that terminal count 0 ends an N-cycle window.
  localparam logic [TW-1:0] CARGA_ABERTA = TW'(T_ABERTA - 1);
  localparam logic [TW-1:0] CARGA_FECHO  = TW'(T_FECHO - 1);
  localparam logic [3:0]    LIMITE       = 4'(LOTACAO);

  estado_t    estado, estado_seg;
  logic [TW-1:0] temp, temp_seg;
  logic       sentido_reg, sentido_seg;
  logic [3:0] cont, cont_seg;
  matricula_t ult_seg;
  logic       recusa_seg;
  logic       cheio_int;
  logic       pedido_ok;
  logic       escrita;

  assign cheio_int = (cont == LIMITE);
  // A request is admissible unless the plate is invalid, an entry finds the
  // lot full, or an exit finds it empty.
  assign pedido_ok = valido
                     && !((sentido == SENTIDO_ENTRADA) && cheio_int)
                     && !((sentido == SENTIDO_SAIDA) && (cont == 4'd0));
  assign escrita   = (estado == REPOUSO) && pedido && pedido_ok;

  // Next-state, timer, count and latch logic.
  always_comb begin
    estado_seg  = estado;
    temp_seg    = temp;
    sentido_seg = sentido_reg;
    cont_seg    = cont;
    ult_seg     = ult_matricula;
    recusa_seg  = 1'b0;
    case (estado)
      REPOUSO: begin
        if (escrita) begin
          estado_seg  = ABERTA;
          temp_seg    = CARGA_ABERTA;
          sentido_seg = sentido;
          ult_seg     = matricula;
        end else if (pedido) begin
          recusa_seg = 1'b1;
        end
      end
      ABERTA: begin
        // Passage takes priority over a coincident timeout.
        if (passou) begin
          estado_seg = FECHO;
          temp_seg   = CARGA_FECHO;
          if ((sentido_reg == SENTIDO_ENTRADA) && (cont < LIMITE))
            cont_seg = cont + 4'd1;
          else if ((sentido_reg == SENTIDO_SAIDA) && (cont != 4'd0))
            cont_seg = cont - 4'd1;
        end else if (temp == '0) begin
          estado_seg = FECHO;
          temp_seg   = CARGA_FECHO;
        end else begin
          temp_seg = temp - 1'b1;
        end
      end
      FECHO: begin
        if (temp == '0) estado_seg = REPOUSO;
        else            temp_seg   = temp - 1'b1;
      end
      default: estado_seg = REPOUSO;
    endcase
  end

  // State and datapath registers; reset discards any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= REPOUSO;
      temp          <= '0;
      sentido_reg   <= SENTIDO_ENTRADA;
      cont          <= 4'd0;
      ult_matricula <= '0;
      recusado      <= 1'b0;
    end else begin
      estado        <= estado_seg;
      temp          <= temp_seg;
      sentido_reg   <= sentido_seg;
      cont          <= cont_seg;
      ult_matricula <= ult_seg;
      recusado      <= recusa_seg;
    end
  end

  assign barreira = (estado == ABERTA);
  assign ocupado  = (estado != REPOUSO);
  assign contagem = cont;
  assign cheio    = cheio_int;

`ifdef GESTOR_REGISTO_EN
  registo_matriculas u_registo (
    .clk        (clk),
    .rst        (rst),
    .escrever   (escrita),
    .dado       (matricula),
    .ler        (ler),
    .hist_dado  (hist_dado),
    .hist_vazio (hist_vazio)
  );
`endif

endmodule

// File: tb/tb_gestor_barreira.sv
// Scoreboard bench for gestor_barreira: a transaction-level model predicts the
// outcome of each request; a monitor measures what the DUT does and compares.
module tb_gestor_barreira;
  import gestor_pkg::*;

  localparam int LOT = 9;
  localparam int TA  = 5;
  localparam int TF  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pedido, valido, sentido, passou;
  logic [23:0] matricula;
  logic        barreira, ocupado, recusado, cheio;
  logic [3:0]  contagem;
  logic [23:0] ult_matricula;
`ifdef GESTOR_REGISTO_EN
  logic        ler;
  logic [23:0] hist_dado;
  logic        hist_vazio;
`endif

  gestor_barreira #(.LOTACAO(LOT), .T_ABERTA(TA), .T_FECHO(TF)) dut (
    .clk           (clk),
    .rst           (rst),
    .pedido        (pedido),
    .valido        (valido),
    .sentido       (sentido),
    .matricula     (matricula),
    .passou        (passou),
    .barreira      (barreira),
    .ocupado       (ocupado),
    .recusado      (recusado),
    .contagem      (contagem),
    .cheio         (cheio),
    .ult_matricula (ult_matricula)
`ifdef GESTOR_REGISTO_EN
    ,
    .ler           (ler),
    .hist_dado     (hist_dado),
    .hist_vazio    (hist_vazio)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit aceita;
    int open_len;
    int fecho_len;
    int cnt;
    int cheio;
    int ult;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_cnt   = 0;
  logic [23:0] m_ult   = '0;
  logic [23:0] m_log[$];

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One request: model predicts the outcome, then the request is driven.
  // pass_at = cycle after pedido in which passou pulses (0 = never);
  // ign_at  = cycle in which an extra pedido is thrown in (0 = never).
  task automatic txn(bit v, bit s, logic [23:0] mat, int pass_at, int ign_at);
    bit   ac;
    int   open_len;
    exp_t e;
    ac = v && !(s == SENTIDO_ENTRADA && m_cnt == LOT) && !(s == SENTIDO_SAIDA && m_cnt == 0);
    if (ac) begin
      m_ult = mat;
      if (pass_at != 0) m_cnt += (s == SENTIDO_SAIDA) ? -1 : 1;
      m_log.push_back(mat);
      if (m_log.size() > 4) void'(m_log.pop_front());
    end
    open_len    = ac ? ((pass_at != 0) ? pass_at : TA) : 0;
    e.aceita    = ac;
    e.open_len  = open_len;
    e.fecho_len = ac ? TF : 0;
    e.cnt       = m_cnt;
    e.cheio     = (m_cnt == LOT) ? 1 : 0;
    e.ult       = int'(m_ult);
    sb.push_back(e);
    pedido = 1'b1; valido = v; sentido = s; matricula = mat;
    @(posedge clk); #1;
    pedido = 1'b0; valido = 1'($urandom); matricula = 24'($urandom);
    for (int c = 1; c <= TA + TF + 3; c++) begin
      // Stray passou pulses only where the barrier is predicted closed.
      passou = (c == pass_at) || (c > open_len && $urandom_range(0, 3) == 0);
      if (c == ign_at) begin
        pedido = 1'b1; valido = 1'b1; sentido = 1'($urandom); matricula = 24'hABCDEF;
      end else begin
        pedido = 1'b0;
      end
      @(posedge clk); #1;
    end
    passou = 1'b0; pedido = 1'b0;
  endtask

  // Monitor: measures each transaction's latency, open/guard lengths and results.
  initial begin
    bit   act;
    int   since, lat, oc, fc;
    exp_t e;
    act = 0; since = 0; lat = -1; oc = 0; fc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
      end else if (!act && pedido && !ocupado) begin
        act = 1; since = 0; lat = -1; oc = 0; fc = 0;
      end else if (act) begin
        since++;
        if (barreira) begin
          oc++;
          if (lat < 0) lat = since;
        end else if (ocupado) begin
          fc++;
        end
        if (recusado) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected_recusa: got recusado=1 expected no pending request");
          end else begin
            e = sb.pop_front();
            chk("recusa_kind", 0, int'(e.aceita));
            chk("recusa_lat", since, 1);
            chk("recusa_barreira", int'(barreira), 0);
            chk("recusa_contagem", int'(contagem), e.cnt);
            chk("recusa_cheio", int'(cheio), e.cheio);
            chk("recusa_ult", int'(ult_matricula), e.ult);
          end
          act = 0;
        end else if (!ocupado) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected_fim: got end of transaction expected no pending request");
          end else begin
            e = sb.pop_front();
            chk("aceita_kind", 1, int'(e.aceita));
            chk("abre_lat", lat, 1);
            chk("abre_ciclos", oc, e.open_len);
            chk("fecho_ciclos", fc, e.fecho_len);
            chk("contagem", int'(contagem), e.cnt);
            chk("cheio", int'(cheio), e.cheio);
            chk("ult_matricula", int'(ult_matricula), e.ult);
          end
          act = 0;
        end else if (since > 40) begin
          chk("mon_timeout", since, 0);
          act = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pedido = 1'b0; valido = 1'b0; sentido = 1'b0; passou = 1'b0; matricula = '0;
`ifdef GESTOR_REGISTO_EN
    ler = 1'b0;
`endif
    #2;
    chk("rst_barreira", int'(barreira), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_recusado", int'(recusado), 0);
    chk("rst_contagem", int'(contagem), 0);
    chk("rst_cheio", int'(cheio), 0);
    chk("rst_ult", int'(ult_matricula), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Entry with passage in cycle 3, then an invalid plate.
    txn(1'b1, SENTIDO_ENTRADA, 24'h12A568, 3, 0);
    txn(1'b0, SENTIDO_ENTRADA, 24'h111111, 2, 0);
    // Back to empty, exit refused, entry left to time out.
    txn(1'b1, SENTIDO_SAIDA, 24'h222222, 1, 0);
    txn(1'b1, SENTIDO_SAIDA, 24'h333333, 2, 0);
    txn(1'b1, SENTIDO_ENTRADA, 24'h444444, 0, 0);
    // Fill to capacity, entry refused when full, one exit.
    for (int i = 0; i < LOT; i++) txn(1'b1, SENTIDO_ENTRADA, 24'(24'h500000 + i), 1 + (i % TA), 0);
    txn(1'b1, SENTIDO_ENTRADA, 24'h600000, 1, 0);
    txn(1'b1, SENTIDO_SAIDA, 24'h700000, 2, 0);
    // Extra pedido while open is ignored; passage coincident with timeout counts.
    txn(1'b1, SENTIDO_ENTRADA, 24'h800000, 4, 2);
    txn(1'b1, SENTIDO_SAIDA, 24'h900000, TA, 0);

    // Reset in the middle of ABERTA, with a passage pending on the same edge.
    pedido = 1'b1; valido = 1'b1; sentido = SENTIDO_ENTRADA; matricula = 24'h777777;
    @(posedge clk); #1;
    pedido = 1'b0;
    @(posedge clk); #1;
    passou = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_barreira", int'(barreira), 0);
    chk("rstmid_ocupado", int'(ocupado), 0);
    chk("rstmid_contagem", int'(contagem), 0);
    chk("rstmid_ult", int'(ult_matricula), 0);
    @(posedge clk); #1;
    rst = 1'b0; passou = 1'b0;
    m_cnt = 0; m_ult = '0; m_log.delete();
    @(posedge clk); #1;
    chk("rstmid_contagem_pos", int'(contagem), 0);
    chk("rstmid_barreira_pos", int'(barreira), 0);

`ifdef GESTOR_REGISTO_EN
    for (int i = 0; i < 5; i++) txn(1'b1, SENTIDO_ENTRADA, 24'($urandom), 2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("log_vazio_n", int'(hist_vazio), 0);
      chk("log_dado", int'(hist_dado), int'(m_log[i]));
      ler = 1'b1;
      @(posedge clk); #1;
      ler = 1'b0;
    end
    chk("log_vazio", int'(hist_vazio), 1);
    m_log.delete();
`endif

    // Randomised traffic, biased towards entries so the lot fills up.
    repeat (60) begin
      bit v, s;
      int pa;
      v  = ($urandom_range(0, 7) != 0);
      s  = ($urandom_range(0, 2) == 0) ? SENTIDO_SAIDA : SENTIDO_ENTRADA;
      pa = $urandom_range(0, TA);
      txn(v, s, 24'($urandom), pa, 0);
    end

    repeat (5) @(posedge clk);
    #1 chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
